// File: rtl/prime_ctrl.sv
// Control FSM for a trial-division primality tester; drives load enables and
// mux selects of an external datapath and reports the verdict on prime.
module prime_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        t_gt_d,
    input  logic        t_eq_d,
    input  logic        t_lt_d,
    input  logic        d_gt_h,
    input  logic        n_lt2,
    output logic        nc,
    output logic        divc,
    output logic        tmp1c,
    output logic        tmp2c,
    output logic        resc,
    output logic        div_sel,
    output logic        tmp1_sel,
    output logic        busy,
    output logic        done,
    output logic        prime,
    output logic [2:0]  state,
    output logic [15:0] cyc
);

    localparam logic [2:0]  S_IDLE  = 3'd0;
    localparam logic [2:0]  S_LOAD  = 3'd1;
    localparam logic [2:0]  S_CHK   = 3'd2;
    localparam logic [2:0]  S_DIVL  = 3'd3;
    localparam logic [2:0]  S_FIN   = 3'd4;
    localparam logic [15:0] CYC_MAX = 16'hFFFF;

    logic [2:0]  state_r;
    logic [2:0]  next_state_s;
    logic        prime_r;
    logic        prime_set_s;
    logic        prime_clr_s;
    logic [15:0] cyc_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; unused codes fall back to IDLE
    always_comb begin
        next_state_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (start) next_state_s = S_LOAD;
                else       next_state_s = S_IDLE;
            end
            S_LOAD: begin
                if (abort) next_state_s = S_IDLE;
                else       next_state_s = S_CHK;
            end
            S_CHK: begin
                if (abort)       next_state_s = S_IDLE;
                else if (n_lt2)  next_state_s = S_FIN;
                else if (d_gt_h) next_state_s = S_FIN;
                else             next_state_s = S_DIVL;
            end
            S_DIVL: begin
                // equality wins so a divisor hit is never missed on flag overlap
                if (abort)       next_state_s = S_IDLE;
                else if (t_eq_d) next_state_s = S_FIN;
                else if (t_gt_d) next_state_s = S_DIVL;
                else if (t_lt_d) next_state_s = S_CHK;
                else             next_state_s = S_DIVL;
            end
            S_FIN:   next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Output decode: datapath enables, selects and verdict updates
    always_comb begin
        nc          = 1'b0;
        divc        = 1'b0;
        tmp1c       = 1'b0;
        tmp2c       = 1'b0;
        resc        = 1'b0;
        div_sel     = 1'b0;
        tmp1_sel    = 1'b0;
        prime_set_s = 1'b0;
        prime_clr_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                nc = start;
            end
            S_LOAD: begin
                if (abort) begin
                    prime_clr_s = 1'b1;
                end else begin
                    tmp2c       = 1'b1;
                    divc        = 1'b1;
                    prime_set_s = 1'b1;
                end
            end
            S_CHK: begin
                if (abort) begin
                    prime_clr_s = 1'b1;
                end else if (n_lt2) begin
                    prime_clr_s = 1'b1;
                end else if (d_gt_h) begin
                    prime_clr_s = 1'b0;
                end else begin
                    tmp1c = 1'b1;
                end
            end
            S_DIVL: begin
                if (abort) begin
                    prime_clr_s = 1'b1;
                end else if (t_eq_d) begin
                    resc        = 1'b1;
                    prime_clr_s = 1'b1;
                end else if (t_gt_d) begin
                    tmp1c    = 1'b1;
                    tmp1_sel = 1'b1;
                end else if (t_lt_d) begin
                    divc    = 1'b1;
                    div_sel = 1'b1;
                end else begin
                    prime_clr_s = 1'b0;
                end
            end
            S_FIN: begin
                prime_clr_s = 1'b0;
            end
            default: begin
                prime_clr_s = 1'b0;
            end
        endcase
    end

    // Verdict register: set on LOAD, cleared on divisor hit, n<2 or abort
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_r <= 1'b0;
        end else if (prime_clr_s) begin
            prime_r <= 1'b0;
        end else if (prime_set_s) begin
            prime_r <= 1'b1;
        end else begin
            prime_r <= prime_r;
        end
    end

    // Busy-cycle counter: restarts when a test is accepted, saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_r <= 16'd0;
        end else if (state_r == S_IDLE) begin
            if (start) cyc_r <= 16'd0;
            else       cyc_r <= cyc_r;
        end else if (cyc_r != CYC_MAX) begin
            cyc_r <= cyc_r + 16'd1;
        end else begin
            cyc_r <= cyc_r;
        end
    end

    assign busy  = (state_r != S_IDLE);
    assign done  = (state_r == S_FIN);
    assign prime = prime_r;
    assign state = state_r;
    assign cyc   = cyc_r;

endmodule
